spi_reg_bridge: RTL and testbench

SPI_REG_BRIDGE -- requirements
Module: spi_reg_bridge

---
 rtl/spi_reg_pkg.sv | 26 ++
 rtl/sync_2ff.sv | 35 +++
 rtl/spi_reg_bridge.sv | 209 ++++++++++++++++++++
 tb/tb_spi_reg_bridge.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI-to-register bridge.
//   state_e   : bridge FSM states
//   FRAME_LEN : frame length at the default field widths
//   frame_len : frame length for arbitrary address/data widths
package spi_reg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_RD_ACCESS,
        ST_DATA,
        ST_WR_ACCESS,
        ST_DONE
    } state_e;

    localparam int unsigned DEF_NB_ADDR = 8;
    localparam int unsigned DEF_NB_DATA = 8;
    localparam int unsigned FRAME_LEN   = 1 + DEF_NB_ADDR + DEF_NB_DATA;

    // R/W bit + address field + data field
    function automatic int unsigned frame_len(input int unsigned nb_addr,
                                              input int unsigned nb_data);
        return 1 + nb_addr + nb_data;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous single-bit inputs, WIDTH bits wide.
//   clk, resetb : clock and async active-low reset
//   d           : asynchronous inputs
//   q           : synchronized outputs (reset to RST_VAL)
module sync_2ff #(
    parameter int unsigned          WIDTH   = 1,
    parameter logic [WIDTH-1:0]     RST_VAL = '0
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI (mode 0) slave to parallel register-bus bridge.
// Frame, MSB first: R/W (1 = read), address[NB_ADDR], data[NB_DATA].
//   clk, resetb              : system clock, async active-low reset
//   spi_sclk/csb/mosi        : asynchronous SPI inputs
//   spi_miso, spi_miso_oe    : SPI read data and its output enable
//   wr_req, rd_req           : one-clk register write / read strobes
//   addr_out, data_wr        : register address / write data
//   data_rd                  : register read data (combinational from slave)
module spi_reg_bridge
    import spi_reg_pkg::*;
#(
    parameter int unsigned NB_DATA = DEF_NB_DATA,
    parameter int unsigned NB_ADDR = DEF_NB_ADDR
) (
    input  logic               clk,
    input  logic               resetb,
    input  logic               spi_sclk,
    input  logic               spi_csb,
    input  logic               spi_mosi,
    output logic               spi_miso,
    output logic               spi_miso_oe,
    output logic               wr_req,
    output logic               rd_req,
    output logic [NB_ADDR-1:0] addr_out,
    output logic [NB_DATA-1:0] data_wr,
    input  logic [NB_DATA-1:0] data_rd
);

    localparam int unsigned FLEN  = frame_len(NB_ADDR, NB_DATA);
    localparam int unsigned CNT_W = $clog2(FLEN + 1);

    // Synchronized SPI inputs; csb idles high
    logic [2:0] sync_vec;
    logic       sclk_s, csb_s, mosi_s;

    sync_2ff #(
        .WIDTH   (3),
        .RST_VAL (3'b010)
    ) u_sync (
        .clk    (clk),
        .resetb (resetb),
        .d      ({spi_sclk, spi_csb, spi_mosi}),
        .q      (sync_vec)
    );

    assign sclk_s = sync_vec[2];
    assign csb_s  = sync_vec[1];
    assign mosi_s = sync_vec[0];

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [NB_ADDR:0]   cmd_sr_q, cmd_sr_d;
    logic [NB_DATA-1:0] data_sr_q, data_sr_d;
    logic [NB_ADDR-1:0] addr_out_q, addr_out_d;
    logic [NB_DATA-1:0] data_wr_q, data_wr_d;
    logic               wr_req_q, wr_req_d;
    logic               rd_req_q, rd_req_d;
    logic               miso_q, miso_d;
    logic               miso_oe_q, miso_oe_d;
    logic               sclk_prev_q, sclk_prev_d;
    logic               csb_prev_q, csb_prev_d;
    logic [1:0]         settle_q, settle_d;

    logic settled, sclk_rise, sclk_fall, csb_fall, rd_mode;

    // The synchronizer reports its reset value for two clocks after reset;
    // csb edges are only trusted once real samples have reached csb_prev_q,
    // so a frame already in progress at reset release is never picked up.
    assign settled   = (settle_q == 2'd3);
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign csb_fall  = settled & csb_prev_q & ~csb_s;
    assign rd_mode   = cmd_sr_q[NB_ADDR];

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmd_sr_d    = cmd_sr_q;
        data_sr_d   = data_sr_q;
        addr_out_d  = addr_out_q;
        data_wr_d   = data_wr_q;
        wr_req_d    = 1'b0;
        rd_req_d    = 1'b0;
        miso_d      = 1'b0;
        miso_oe_d   = 1'b0;
        sclk_prev_d = sclk_s;
        csb_prev_d  = csb_s;
        settle_d    = settled ? settle_q : settle_q + 2'd1;
        cnt_inc     = (cnt_q == CNT_W'(FLEN)) ? cnt_q : cnt_q + CNT_W'(1);

        unique case (state_q)
            ST_IDLE: begin
                if (csb_fall) begin
                    state_d = ST_CMD;
                    cnt_d   = '0;
                end
            end
            ST_CMD: begin
                if (sclk_rise) begin
                    cmd_sr_d = {cmd_sr_q[NB_ADDR-1:0], mosi_s};
                    cnt_d    = cnt_inc;
                    if (cnt_q == CNT_W'(NB_ADDR)) begin
                        if (cmd_sr_d[NB_ADDR]) begin
                            state_d    = ST_RD_ACCESS;
                            rd_req_d   = 1'b1;
                            addr_out_d = cmd_sr_d[NB_ADDR-1:0];
                        end else begin
                            state_d = ST_DATA;
                        end
                    end
                end
            end
            ST_RD_ACCESS: begin
                data_sr_d = data_rd;
                miso_oe_d = 1'b1;
                state_d   = ST_DATA;
            end
            ST_DATA: begin
                if (rd_mode) begin
                    miso_oe_d = 1'b1;
                    miso_d    = miso_q;
                    if (sclk_fall) begin
                        miso_d    = data_sr_q[NB_DATA-1];
                        data_sr_d = {data_sr_q[NB_DATA-2:0], 1'b0};
                    end
                    if (sclk_rise) begin
                        cnt_d = cnt_inc;
                        if (cnt_q == CNT_W'(FLEN - 1)) begin
                            state_d   = ST_DONE;
                            miso_oe_d = 1'b0;
                            miso_d    = 1'b0;
                        end
                    end
                end else if (sclk_rise) begin
                    data_sr_d = {data_sr_q[NB_DATA-2:0], mosi_s};
                    cnt_d     = cnt_inc;
                    if (cnt_q == CNT_W'(FLEN - 1)) begin
                        state_d    = ST_WR_ACCESS;
                        wr_req_d   = 1'b1;
                        addr_out_d = cmd_sr_q[NB_ADDR-1:0];
                        data_wr_d  = data_sr_d;
                    end
                end
            end
            ST_WR_ACCESS: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // csb high ends any frame: nothing further is issued or driven
        if ((state_q != ST_IDLE) && csb_s) begin
            state_d    = ST_IDLE;
            wr_req_d   = 1'b0;
            rd_req_d   = 1'b0;
            miso_d     = 1'b0;
            miso_oe_d  = 1'b0;
            addr_out_d = addr_out_q;
            data_wr_d  = data_wr_q;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cmd_sr_q    <= '0;
            data_sr_q   <= '0;
            addr_out_q  <= '0;
            data_wr_q   <= '0;
            wr_req_q    <= 1'b0;
            rd_req_q    <= 1'b0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            sclk_prev_q <= 1'b0;
            csb_prev_q  <= 1'b1;
            settle_q    <= 2'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_sr_q    <= cmd_sr_d;
            data_sr_q   <= data_sr_d;
            addr_out_q  <= addr_out_d;
            data_wr_q   <= data_wr_d;
            wr_req_q    <= wr_req_d;
            rd_req_q    <= rd_req_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
            sclk_prev_q <= sclk_prev_d;
            csb_prev_q  <= csb_prev_d;
            settle_q    <= settle_d;
        end
    end

    assign spi_miso    = miso_q;
    assign spi_miso_oe = miso_oe_q;
    assign wr_req      = wr_req_q;
    assign rd_req      = rd_req_q;
    assign addr_out    = addr_out_q;
    assign data_wr     = data_wr_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Self-checking bench for spi_reg_bridge: directed scenarios plus random
// frames, checked against a register-file model and per-frame expectations.
module tb_spi_reg_bridge;
    import spi_reg_pkg::*;

    localparam int HALF = 6;  // sclk half period in clk cycles (sclk = clk/12)

    logic       clk, resetb;
    logic       spi_sclk, spi_csb, spi_mosi;
    logic       spi_miso, spi_miso_oe;
    logic       wr_req, rd_req;
    logic [7:0] addr_out, data_wr, data_rd;

    spi_reg_bridge #(.NB_DATA(8), .NB_ADDR(8)) dut (
        .clk         (clk),
        .resetb      (resetb),
        .spi_sclk    (spi_sclk),
        .spi_csb     (spi_csb),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .wr_req      (wr_req),
        .rd_req      (rd_req),
        .addr_out    (addr_out),
        .data_wr     (data_wr),
        .data_rd     (data_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int viol    = 0;

    // Register slave seen by the DUT, and the bench's model of its contents
    logic [7:0]  slave_mem [256];
    logic [7:0]  model_mem [256];
    logic [15:0] wr_q [$];
    logic [7:0]  rd_q [$];

    assign data_rd = slave_mem[addr_out];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Bus monitor: log strobes, act as register slave, flag illegal combinations
    always @(negedge clk) begin
        if (resetb) begin
            if (wr_req && rd_req) viol++;
            if (!spi_miso_oe && spi_miso) viol++;
            if (wr_req) begin
                wr_q.push_back({addr_out, data_wr});
                slave_mem[addr_out] = data_wr;
            end
            if (rd_req) rd_q.push_back(addr_out);
        end
    end

    // Lower csb and clock out nbits; record oe errors and the sampled miso byte
    task automatic send_bits(input logic rw, input logic [7:0] a, input logic [7:0] d,
                             input int nbits, output int oe_err, output logic [7:0] mb);
        logic [16:0] f;
        logic        exp_oe;
        f      = {rw, a, d};
        oe_err = 0;
        mb     = 8'h00;
        spi_csb = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = (i < 17) ? f[16-i] : 1'($urandom);
            repeat (HALF) @(negedge clk);
            exp_oe = rw && (i >= 9) && (i <= 16);
            if (spi_miso_oe !== exp_oe) oe_err++;
            if (i >= 9 && i <= 16) mb[16-i] = spi_miso;
            spi_sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            spi_sclk = 1'b0;
        end
        repeat (HALF) @(negedge clk);
    endtask

    // Full frame (possibly short/long), csb release, and result checks
    task automatic run_frame(input logic rw, input logic [7:0] a, input logic [7:0] d,
                             input int nbits, input int gap);
        int         oe_err, k;
        logic [7:0] mb, mask, exp_rd;
        logic       exp_wr, exp_rdq, post_oe;
        wr_q.delete();
        rd_q.delete();
        exp_rd = model_mem[a];
        send_bits(rw, a, d, nbits, oe_err, mb);
        post_oe = rw && (nbits >= 9) && (nbits < 17);
        if (spi_miso_oe !== post_oe) oe_err++;
        chk("oe_during_frame", 32'(oe_err), 32'd0);
        spi_csb = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_after_csb", 32'(dut.state_q), 32'(ST_IDLE));
        chk("miso_oe_after_csb", {30'd0, spi_miso_oe, spi_miso}, 32'd0);
        repeat (gap - 3) @(negedge clk);

        exp_wr  = !rw && (nbits >= 17);
        exp_rdq = rw && (nbits >= 9);
        chk("wr_count", 32'(wr_q.size()), 32'(exp_wr));
        chk("rd_count", 32'(rd_q.size()), 32'(exp_rdq));
        if (exp_wr && wr_q.size() > 0) chk("wr_payload", 32'(wr_q[0]), {16'd0, a, d});
        if (exp_rdq && rd_q.size() > 0) chk("rd_addr", 32'(rd_q[0]), {24'd0, a});
        k = (nbits >= 17) ? 8 : ((nbits > 9) ? nbits - 9 : 0);
        if (rw && k > 0) begin
            mask = 8'hFF;
            mask = mask << (8 - k);
            chk("miso_data", 32'(mb & mask), 32'(exp_rd & mask));
        end
        if (exp_wr) model_mem[a] = d;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int         oe_err, nb, sel;
        logic [7:0] mb, a, d;
        logic       rw;

        for (int i = 0; i < 256; i++) begin
            slave_mem[i] = 8'($urandom);
            model_mem[i] = slave_mem[i];
        end
        spi_sclk = 1'b0;
        spi_csb  = 1'b1;
        spi_mosi = 1'b0;
        resetb   = 1'b0;
        repeat (4) @(negedge clk);
        chk("reset_outputs", {12'd0, wr_req, rd_req, addr_out, data_wr, spi_miso, spi_miso_oe}, 32'd0);
        resetb = 1'b1;
        repeat (6) @(negedge clk);

        // Basic write
        run_frame(1'b0, 8'h34, 8'hA5, 17, 8);
        chk("wr_addr_hold", 32'(addr_out), 32'h34);
        chk("wr_data_hold", 32'(data_wr), 32'hA5);

        // Basic read, MSB only set
        slave_mem[8'h00] = 8'h80;
        model_mem[8'h00] = 8'h80;
        run_frame(1'b1, 8'h00, 8'h00, 17, 8);

        // Aborted write, then a full write and readback to the same address
        run_frame(1'b0, 8'h52, 8'h3C, 12, 8);
        chk("abort_keeps_addr", 32'(addr_out), 32'h00);
        run_frame(1'b0, 8'h52, 8'h3C, 17, 8);
        run_frame(1'b1, 8'h52, 8'h00, 17, 8);

        // Over-long write: extra clocks ignored
        run_frame(1'b0, 8'h11, 8'h5A, 20, 8);

        // Back-to-back writes with short csb high time
        run_frame(1'b0, 8'h00, 8'h80, 17, 4);
        run_frame(1'b0, 8'h34, 8'h84, 17, 4);
        run_frame(1'b1, 8'h34, 8'h00, 17, 8);

        // Reset mid-read; frame in progress at release must be discarded
        wr_q.delete();
        rd_q.delete();
        send_bits(1'b1, 8'h68, 8'h00, 5, oe_err, mb);
        resetb = 1'b0;
        #1;
        chk("async_reset_outputs", {12'd0, wr_req, rd_req, addr_out, data_wr, spi_miso, spi_miso_oe}, 32'd0);
        repeat (3) @(negedge clk);
        resetb = 1'b1;
        for (int i = 0; i < 12; i++) begin
            spi_mosi = 1'($urandom);
            repeat (HALF) @(negedge clk);
            spi_sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            spi_sclk = 1'b0;
        end
        chk("post_reset_oe", 32'(spi_miso_oe), 32'd0);
        spi_csb = 1'b1;
        repeat (6) @(negedge clk);
        chk("post_reset_no_req", 32'(wr_q.size() + rd_q.size()), 32'd0);
        slave_mem[8'h68] = 8'hFC;
        model_mem[8'h68] = 8'hFC;
        run_frame(1'b1, 8'h68, 8'h00, 17, 8);

        // Random frames: mostly complete, some long, some aborted
        for (int n = 0; n < 40; n++) begin
            rw  = 1'($urandom);
            a   = 8'($urandom);
            d   = 8'($urandom);
            sel = int'($urandom_range(0, 9));
            if (sel <= 6)      nb = 17;
            else if (sel == 7) nb = 17 + int'($urandom_range(1, 4));
            else               nb = int'($urandom_range(1, 16));
            run_frame(rw, a, d, nb, 4 + int'($urandom_range(0, 4)));
        end

        chk("protocol_violations", 32'(viol), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
